// File: rtl/pc_unit_pkg.sv
// pc_unit_pkg: shared select type, PC step and address alignment for the fetch-stage PC unit.
package pc_unit_pkg;
   typedef enum logic [1:0] {NEXT, BRANCH, JUMP, RETURN} t_pc_sel;
   localparam int PC_STEP = 4;
   localparam int MAX_W = 64;
   function automatic logic [MAX_W-1:0] align(input logic [MAX_W-1:0] a);
      return {a[MAX_W-1:2], 2'b00};
   endfunction
endpackage

// File: rtl/pc_ret_stack.sv
// pc_ret_stack: return-address LIFO; push with pop replaces the top entry in place.
module pc_ret_stack #(
   parameter int WIDTH = 32,
   parameter int STACK_DEPTH = 4,
   localparam int DW = $clog2(STACK_DEPTH + 1),
   localparam int IW = STACK_DEPTH > 1 ? $clog2(STACK_DEPTH) : 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] data,
   output logic [WIDTH-1:0] top,
   output logic [DW-1:0]    depth,
   output logic             full,
   output logic             empty
);
   logic [WIDTH-1:0] mem [2**IW];
   logic do_push, do_pop;
   logic [IW-1:0] top_idx, wr_idx;
   assign empty = depth == '0;
   assign full = depth == DW'(STACK_DEPTH);
   assign do_pop = pop & !empty;
   assign do_push = push & (!full | do_pop);
   assign top_idx = IW'(depth - 1'b1);
   assign wr_idx = do_pop ? top_idx : IW'(depth);
   assign top = mem[top_idx];
   // Contents are don't-care after reset, so the array carries no reset.
   always_ff @(posedge clk)
      if (do_push) mem[wr_idx] <= data;
   always_ff @(posedge clk or posedge reset)
      if (reset) depth <= '0;
      else if (do_push != do_pop) depth <= do_push ? depth + 1'b1 : depth - 1'b1;
endmodule

// File: rtl/pc_unit.sv
// pc_unit: registered program counter with four-way next-PC select and nested interrupt entry.
module pc_unit
   import pc_unit_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter logic [WIDTH-1:0] RESET_ADDR = '0,
   parameter int STACK_DEPTH = 4,
   localparam int DW = $clog2(STACK_DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             stall,
   input  t_pc_sel          sel,
   input  logic [WIDTH-1:0] branch_target,
   input  logic [WIDTH-1:0] jump_target,
   input  logic             int_req,
   input  logic [WIDTH-1:0] int_vec,
   output logic [WIDTH-1:0] pc,
   output logic [WIDTH-1:0] pc_plus4,
   output logic             int_ack,
   output logic [DW-1:0]    depth,
   output logic             full,
   output logic             err_underflow
);
   logic [WIDTH-1:0] br, jp, iv, top, top_a, seq_next;
   logic empty, ret, accept, push, pop;
   assign br = WIDTH'(align(MAX_W'(branch_target)));
   assign jp = WIDTH'(align(MAX_W'(jump_target)));
   assign iv = WIDTH'(align(MAX_W'(int_vec)));
   assign top_a = WIDTH'(align(MAX_W'(top)));
   assign pc_plus4 = pc + WIDTH'(PC_STEP);
   // A RETURN with an accepted interrupt pops and pushes together, so the popped address goes straight back.
   always_comb begin
      ret = (sel == RETURN) & !stall;
      accept = int_req & !stall & !full;
      pop = ret & !empty;
      push = accept;
      seq_next = sel == BRANCH ? br :
                 sel == JUMP ? jp :
                 (sel == RETURN && !empty) ? top_a : pc_plus4;
   end
   pc_ret_stack #(.WIDTH(WIDTH), .STACK_DEPTH(STACK_DEPTH)) u_stack (
      .clk(clk),
      .reset(reset),
      .push(push),
      .pop(pop),
      .data(seq_next),
      .top(top),
      .depth(depth),
      .full(full),
      .empty(empty)
   );
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         pc <= RESET_ADDR;
         int_ack <= 1'b0;
         err_underflow <= 1'b0;
      end else begin
         int_ack <= accept;
         if (!stall) pc <= accept ? iv : seq_next;
         if (ret && empty) err_underflow <= 1'b1;
      end
endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed checks of the PC unit (32-bit, 2-deep stack) plus an 8-bit wrap instance.
module tb_pc_unit;
   import pc_unit_pkg::*;
   logic clk = 1'b0, reset = 1'b1, stall = 1'b0, int_req = 1'b0;
   t_pc_sel sel = NEXT;
   logic [31:0] branch_target = '0, jump_target = '0, int_vec = '0;
   logic [31:0] a_pc, a_pc_plus4;
   logic a_ack, a_full, a_err;
   logic [1:0] a_depth;
   t_pc_sel b_sel = NEXT;
   logic [7:0] b_zero = '0;
   logic [7:0] b_pc, b_pc_plus4;
   logic b_ack, b_full, b_err;
   logic [2:0] b_depth;
   int passed = 0, total = 0;

   always #5 clk = ~clk;

   pc_unit #(.WIDTH(32), .RESET_ADDR(32'h0), .STACK_DEPTH(2)) dut_a (
      .clk(clk), .reset(reset), .stall(stall), .sel(sel),
      .branch_target(branch_target), .jump_target(jump_target),
      .int_req(int_req), .int_vec(int_vec),
      .pc(a_pc), .pc_plus4(a_pc_plus4), .int_ack(a_ack),
      .depth(a_depth), .full(a_full), .err_underflow(a_err)
   );

   pc_unit #(.WIDTH(8), .RESET_ADDR(8'hF8), .STACK_DEPTH(4)) dut_b (
      .clk(clk), .reset(reset), .stall(1'b0), .sel(b_sel),
      .branch_target(b_zero), .jump_target(b_zero),
      .int_req(1'b0), .int_vec(b_zero),
      .pc(b_pc), .pc_plus4(b_pc_plus4), .int_ack(b_ack),
      .depth(b_depth), .full(b_full), .err_underflow(b_err)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic state(input string tag, input logic [31:0] pc, input logic ack, input logic [1:0] dep);
      chk({tag, "_pc"}, a_pc, pc);
      chk({tag, "_ack"}, a_ack, ack);
      chk({tag, "_depth"}, a_depth, dep);
   endtask

   initial begin
      #12;
      state("rst", 32'h0, 1'b0, 2'd0);
      chk("rst_err", a_err, 1'b0);
      chk("rst_b_pc", b_pc, 8'hF8);
      reset = 1'b0;
      step(); state("seq1", 32'h4, 1'b0, 2'd0);
      step(); state("seq2", 32'h8, 1'b0, 2'd0);
      step(); state("seq3", 32'hC, 1'b0, 2'd0);
      chk("plus4", a_pc_plus4, 32'h10);
      step(); chk("seq4", a_pc, 32'h10);
      sel = BRANCH; branch_target = 32'h103;
      step(); chk("branch", a_pc, 32'h100);
      sel = JUMP; jump_target = 32'h2000;
      step(); chk("jump", a_pc, 32'h2000);
      jump_target = 32'h20;
      step(); chk("jump20", a_pc, 32'h20);
      sel = NEXT; int_req = 1'b1; int_vec = 32'h400;
      step(); state("int", 32'h400, 1'b1, 2'd1);
      int_req = 1'b0;
      step(); state("isr", 32'h404, 1'b0, 2'd1);
      sel = RETURN;
      step(); state("ret", 32'h24, 1'b0, 2'd0);
      chk("ret_err", a_err, 1'b0);
      sel = JUMP; jump_target = 32'h50;
      step(); chk("jump50", a_pc, 32'h50);
      sel = RETURN;
      step(); state("under", 32'h54, 1'b0, 2'd0);
      chk("under_err", a_err, 1'b1);
      sel = NEXT;
      step(); chk("sticky_pc", a_pc, 32'h58);
      chk("sticky_err", a_err, 1'b1);
      int_req = 1'b1; int_vec = 32'h400;
      step(); state("nest1", 32'h400, 1'b1, 2'd1);
      chk("nest1_full", a_full, 1'b0);
      int_vec = 32'h801;
      step(); state("nest2", 32'h800, 1'b1, 2'd2);
      chk("nest2_full", a_full, 1'b1);
      step(); state("held", 32'h804, 1'b0, 2'd2);
      sel = RETURN;
      step(); state("free", 32'h404, 1'b0, 2'd1);
      sel = NEXT;
      step(); state("late", 32'h800, 1'b1, 2'd2);
      int_req = 1'b0; sel = RETURN;
      step(); state("pop2", 32'h408, 1'b0, 2'd1);
      step(); state("pop1", 32'h5C, 1'b0, 2'd0);
      sel = NEXT; int_req = 1'b1; int_vec = 32'h400;
      step(); state("tc_in", 32'h400, 1'b1, 2'd1);
      sel = RETURN; int_vec = 32'h800;
      step(); state("tail", 32'h800, 1'b1, 2'd1);
      int_req = 1'b0;
      step(); state("tail_ret", 32'h60, 1'b0, 2'd0);
      sel = JUMP; jump_target = 32'h40;
      step(); chk("jump40", a_pc, 32'h40);
      sel = NEXT; stall = 1'b1; int_req = 1'b1; int_vec = 32'h400;
      for (int i = 0; i < 3; i++) begin
         step(); state($sformatf("stall%0d", i), 32'h40, 1'b0, 2'd0);
      end
      stall = 1'b0;
      step(); state("unstall", 32'h400, 1'b1, 2'd1);
      int_req = 1'b0; sel = RETURN;
      step(); state("unstall_ret", 32'h44, 1'b0, 2'd0);
      sel = NEXT; int_req = 1'b1;
      step(); state("pre_rst", 32'h400, 1'b1, 2'd1);
      int_req = 1'b0;
      #2 reset = 1'b1;
      #1;
      state("async_rst", 32'h0, 1'b0, 2'd0);
      chk("async_rst_err", a_err, 1'b0);
      chk("async_rst_b", b_pc, 8'hF8);
      reset = 1'b0;
      step(); chk("b_fc", b_pc, 8'hFC);
      chk("b_plus4_wrap", b_pc_plus4, 8'h00);
      step(); chk("b_wrap", b_pc, 8'h00);
      chk("post_rst_a", a_pc, 32'h8);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Successor of the combinational PC select mux.
- Registered program counter, parametrised in width and reset address.
- Four-way next-PC selection: sequential, branch, jump, return.
- Hardware interrupt entry with a req/ack handshake, backed by an internal return-address LIFO that supports nested interrupts. Sits at the head of the fetch stage; its PC output drives instruction memory.

Parameters:
- WIDTH, 32: PC and target width in bits, minimum 8.
- RESET_ADDR, 'h0000_0000: PC value on reset; bits [1:0] must be 0.
- STACK_DEPTH, 4: return-address LIFO entries, minimum 1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- stall  in  1  hold all state this cycle.
- sel  in  pc_unit_pkg::t_pc_sel  next-PC source: NEXT, BRANCH, JUMP, RETURN.
- branch_target  in  WIDTH  branch destination.
- jump_target  in  WIDTH  jump destination.
- int_req  in  1  interrupt request, level, held until acked.
- int_vec  in  WIDTH  interrupt handler address.
- pc  out  WIDTH  current PC, registered.
- pc_plus4  out  WIDTH  pc+4, combinational.
- int_ack  out  1  one-cycle pulse, registered.
- depth  out  $clog2(STACK_DEPTH+1)  LIFO occupancy.
- full  out  1  depth == STACK_DEPTH.
- err_underflow  out  1  sticky: RETURN issued with empty LIFO.

Behaviour:
- Reset, asynchronous: pc=RESET_ADDR, depth=0, int_ack=0, err_underflow=0. LIFO contents don't-care.
- Target alignment: bits [1:0] of branch_target, jump_target, int_vec and popped addresses are forced to 0 before use.
- pc_plus4 = pc + 4, modulo 2^WIDTH; wraps from all-ones region to low addresses silently.
- Candidate address "seq_next", by sel:
  - NEXT: pc_plus4.
  - BRANCH: branch_target.
  - JUMP: jump_target.
  - RETURN: LIFO top, popped. If depth==0: seq_next=pc_plus4, no pop, err_underflow set.
- Interrupt acceptance condition: int_req & !stall & !full.
- On each rising clk with stall=0:
  - Interrupt accepted: pc <= int_vec; push seq_next; int_ack <= 1.
  - Otherwise: pc <= seq_next; int_ack <= 0.
- int_ack is high in exactly the cycle where pc first equals int_vec. The requester must drop or change int_req in that cycle, otherwise a second nested entry occurs.
- stall=1: pc, LIFO and depth hold; int_ack <= 0; err_underflow unchanged. int_req is not accepted and stays pending.
- Simultaneous RETURN and accepted interrupt (tail chaining):
  - Popped address is pushed straight back.
  - depth unchanged; pc <= int_vec.
  - With depth==0: pc_plus4 is pushed, depth becomes 1, err_underflow is set.
- full=1 with int_req: not accepted, no ack; normal sel path applies. A RETURN in that cycle frees an entry; acceptance happens the following cycle.
- depth changes by at most 1 per cycle.
- Reset mid-operation discards pending nesting immediately.
- No combinational path from inputs to pc or int_ack.

Decomposition:
- pc_unit_pkg holds:
  - typedef enum logic [1:0] t_pc_sel {NEXT, BRANCH, JUMP, RETURN}.
  - Constant PC_STEP = 4.
  - Function align(), which clears bits [1:0].
  - The old pc_mux_pkg select type is superseded by t_pc_sel.
- Sub-module pc_ret_stack: parametrised LIFO (WIDTH, STACK_DEPTH).
  - Inputs: push, pop, simultaneous push+pop replaces top, push data.
  - Outputs: top, depth, full, empty.
  - Async reset clears depth.

Test Plan:
- Reset then 3 cycles sel=NEXT, RESET_ADDR=0 → pc 0, 4, 8, 'hC; int_ack=0, depth=0.
- pc='h10, sel=BRANCH, branch_target='h103 → next pc='h100; then sel=JUMP, jump_target='h2000 → pc='h2000.
- pc='h20, sel=NEXT, int_req=1, int_vec='h400:
  - next pc='h400, int_ack=1 for one cycle, depth=1.
  - Later sel=RETURN → pc='h24, depth=0.
- Nesting with STACK_DEPTH=2:
  - Two interrupts accepted → full=1.
  - Third int_req held → no ack, pc advances by 4.
  - One RETURN → ack the cycle after.
- stall=1 for 3 cycles with int_req=1, pc='h40 → pc stays 'h40, no ack. Releasing stall → pc=int_vec, ack.
- Boundary and reset cases:
  - RETURN with depth=0 at pc='h50 → pc='h54, err_underflow=1 and sticky.
  - WIDTH=8, pc='hFC, NEXT → pc='h00.
  - Async reset asserted mid-cycle → pc=RESET_ADDR immediately, depth=0.
